// File: rtl/f1_start_sequencer.sv
// Formula 1 start-light sequencer: fills the light bank one lamp per tick, then holds for an LFSR-chosen delay.
// Optional macro ABORT_EN adds an `abort` input that cancels a running sequence.
module f1_start_sequencer #(
   parameter int CLK_DIV    = 4,
   parameter int NUM_LIGHTS = 8,
   parameter int LFSR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trigger,
`ifdef ABORT_EN
   input  logic                  abort,
`endif
   output logic [NUM_LIGHTS-1:0] data_out,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, SEQ, DELAY} state_t;

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t                state;
   logic [CW-1:0]         tick_cnt;
   logic [LFSR_WIDTH-1:0] delay_cnt;
   logic [LFSR_WIDTH-1:0] lfsr;
   logic                  tick;
   logic                  abort_req;
   logic                  all_on;
   logic [LFSR_WIDTH-1:0] lfsr_next;

`ifdef ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign tick   = (tick_cnt == CW'(CLK_DIV - 1));
   assign all_on = &data_out;
   assign busy   = (state != IDLE);

   // x^7+x^6+1 Fibonacci LFSR; the taps assume the 7-bit width.
   assign lfsr_next = {lfsr[LFSR_WIDTH-2:0], lfsr[6] ^ lfsr[5]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         data_out  <= '0;
         done      <= 1'b0;
         tick_cnt  <= '0;
         delay_cnt <= '0;
         lfsr      <= LFSR_WIDTH'(1);
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tick_cnt <= '0;
               data_out <= '0;
               if (trigger) begin
                  state    <= SEQ;
                  data_out <= NUM_LIGHTS'(1);
                  lfsr     <= lfsr_next;
               end
            end
            SEQ, DELAY: begin
               // Abort takes priority over any tick landing on the same edge.
               if (abort_req) begin
                  state     <= IDLE;
                  data_out  <= '0;
                  tick_cnt  <= '0;
                  delay_cnt <= '0;
               end else begin
                  tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
                  if (tick) begin
                     if (state == SEQ) begin
                        if (all_on) begin
                           state     <= DELAY;
                           delay_cnt <= lfsr;
                        end else begin
                           data_out <= {data_out[NUM_LIGHTS-2:0], 1'b1};
                        end
                     end else if (delay_cnt > LFSR_WIDTH'(1)) begin
                        delay_cnt <= delay_cnt - LFSR_WIDTH'(1);
                     end else begin
                        data_out  <= '0;
                        done      <= 1'b1;
                        delay_cnt <= '0;
                        state     <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed bench for f1_start_sequencer: checkpoint table for a full L=2 sequence plus hand-written corner cases.
module tb_f1_start_sequencer;

   localparam int CLK_DIV    = 4;
   localparam int NUM_LIGHTS = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       trigger = 1'b0;
   logic [7:0] data_out;
   logic       busy;
   logic       done;
`ifdef ABORT_EN
   logic       abort = 1'b0;
`endif

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int         off;
      logic [7:0] data;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   f1_start_sequencer #(
      .CLK_DIV   (CLK_DIV),
      .NUM_LIGHTS(NUM_LIGHTS),
      .LFSR_WIDTH(7)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .trigger (trigger),
`ifdef ABORT_EN
      .abort   (abort),
`endif
      .data_out(data_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] d, input logic b, input logic dn);
      compared++;
      if (data_out !== d || busy !== b || done !== dn) begin
         mismatched++;
         $display("[TB] FAIL %s: got data=%h busy=%b done=%b, want data=%h busy=%b done=%b",
                  name, data_out, busy, done, d, b, dn);
      end
   endtask

   task automatic checkCount(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      stepEdge();
      stepEdge();
      rst = 1'b0;
   endtask

   // Returns at edge k, i.e. just after the edge that sampled the trigger.
   task automatic applyStimulus();
      trigger = 1'b1;
      stepEdge();
      trigger = 1'b0;
   endtask

   // Full L=2 sequence checked against the table; optional ignored trigger pulses while busy.
   task automatic runTable(input string tag, input bit pulses);
      int dones = 0;
      applyStimulus();
      for (int t = 0; t <= 45; t++) begin
         if (t > 0) begin
            trigger = pulses && (t == 5 || t == 20 || t == 33);
            stepEdge();
            trigger = 1'b0;
         end
         if (done) dones++;
         foreach (vecs[i])
            if (vecs[i].off == t)
               checkOutput($sformatf("%s t=%0d", tag, t), vecs[i].data, vecs[i].busy, vecs[i].done);
      end
      checkCount({tag, " done pulses"}, dones, 1);
   endtask

   // Steps until done or the budget runs out; reports the edge offset of the first done.
   task automatic waitDone(input int limit, output int at, output int count);
      at = -1;
      count = 0;
      for (int t = 1; t <= limit; t++) begin
         stepEdge();
         if (done) begin
            count++;
            if (at < 0) at = t;
         end
      end
   endtask

   initial begin
      int at;
      int cnt;

      vecs.push_back('{0,  8'h01, 1'b1, 1'b0});
      vecs.push_back('{3,  8'h01, 1'b1, 1'b0});
      vecs.push_back('{4,  8'h03, 1'b1, 1'b0});
      vecs.push_back('{8,  8'h07, 1'b1, 1'b0});
      vecs.push_back('{12, 8'h0F, 1'b1, 1'b0});
      vecs.push_back('{16, 8'h1F, 1'b1, 1'b0});
      vecs.push_back('{20, 8'h3F, 1'b1, 1'b0});
      vecs.push_back('{24, 8'h7F, 1'b1, 1'b0});
      vecs.push_back('{27, 8'h7F, 1'b1, 1'b0});
      vecs.push_back('{28, 8'hFF, 1'b1, 1'b0});
      vecs.push_back('{32, 8'hFF, 1'b1, 1'b0});
      vecs.push_back('{39, 8'hFF, 1'b1, 1'b0});
      vecs.push_back('{40, 8'h00, 1'b0, 1'b1});
      vecs.push_back('{41, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{45, 8'h00, 1'b0, 1'b0});

      // Reset and idle with no trigger.
      applyReset();
      checkOutput("reset state", 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         stepEdge();
         checkOutput($sformatf("idle %0d", i), 8'h00, 1'b0, 1'b0);
      end

      // First sequence uses L=2.
      runTable("seq1", 1'b0);

      // Second sequence uses L=4: done at k+48.
      applyStimulus();
      checkOutput("seq2 start", 8'h01, 1'b1, 1'b0);
      waitDone(60, at, cnt);
      checkCount("seq2 done edge", at, 48);
      checkCount("seq2 done pulses", cnt, 1);

      // Trigger held high: L=8 -> done at k+64, restart on the very next edge.
      trigger = 1'b1;
      stepEdge();
      at = -1;
      for (int t = 1; t <= 66; t++) begin
         stepEdge();
         if (done && at < 0) at = t;
         if (t == 65) checkOutput("held trigger restart", 8'h01, 1'b1, 1'b0);
      end
      checkCount("held trigger done edge", at, 64);
      trigger = 1'b0;

      // After reset the LFSR restarts, so pulses during the run change nothing.
      applyReset();
      runTable("pulsed", 1'b1);

      // Reset mid-sequence, then confirm the LFSR was reset too.
      applyStimulus();
      for (int t = 1; t <= 14; t++) stepEdge();
      checkOutput("pre-reset t=14", 8'h0F, 1'b1, 1'b0);
      rst = 1'b1;
      stepEdge();
      checkOutput("mid reset", 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      waitDone(6, at, cnt);
      checkCount("done after reset", cnt, 0);
      runTable("post-reset", 1'b0);

`ifdef ABORT_EN
      applyReset();
      applyStimulus();
      for (int t = 1; t <= 33; t++) stepEdge();
      checkOutput("pre-abort delay", 8'hFF, 1'b1, 1'b0);
      abort = 1'b1;
      stepEdge();
      abort = 1'b0;
      checkOutput("abort", 8'h00, 1'b0, 1'b0);
      waitDone(60, at, cnt);
      checkCount("done after abort", cnt, 0);
      applyStimulus();
      waitDone(60, at, cnt);
      checkCount("post-abort done edge", at, 48);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
